// File: rtl/uart_rx_display.sv
// Pairs UART bytes into 4-digit hex messages and drives a multiplexed
// active-low 7-segment display; corrupted or stalled messages are dropped.
module uart_rx_display #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] Rx_DATA,
  input  logic       Rx_VALID,
  input  logic       Rx_PERROR,
  input  logic       Rx_FERROR,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       msg_ok,
  output logic       msg_err,
  output logic       msg_timeout
);

  localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE = 1'b0, HALF = 1'b1} state_t;
  typedef enum logic [1:0] {BLANK = 2'd0, DATA = 2'd1, ERROR = 2'd2} mode_t;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  state_t         r_state, w_state_nxt;
  mode_t          r_mode;
  logic [7:0]     r_hold;
  logic [3:0][3:0] r_digits;
  logic [TW-1:0]  r_timer;
  logic [RW-1:0]  r_refresh;
  logic [1:0]     r_idx;
  logic           r_prev;

  logic w_lvl, w_evt, w_bad, w_expire;
  logic w_load_hold, w_commit, w_err, w_tmo, w_timer_inc;

  assign w_lvl    = Rx_VALID | Rx_PERROR | Rx_FERROR;
  assign w_evt    = w_lvl & ~r_prev;
  assign w_bad    = Rx_PERROR | Rx_FERROR;
  assign w_expire = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-event control; an event always beats timeout expiry
  always_comb begin
    w_state_nxt = r_state;
    w_load_hold = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_tmo       = 1'b0;
    w_timer_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_evt && w_bad) begin
          w_err = 1'b1;
        end else if (w_evt) begin
          w_load_hold = 1'b1;
          w_state_nxt = HALF;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HALF: begin
        if (w_evt) begin
          w_err       = w_bad;
          w_commit    = ~w_bad;
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Message datapath and result pulses
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_prev      <= 1'b0;
      r_hold      <= 8'h00;
      r_digits    <= 16'h0000;
      r_timer     <= '0;
      r_mode      <= BLANK;
      msg_ok      <= 1'b0;
      msg_err     <= 1'b0;
      msg_timeout <= 1'b0;
    end else begin
      r_prev      <= w_lvl;
      msg_ok      <= w_commit;
      msg_err     <= w_err;
      msg_timeout <= w_tmo;
      if (w_load_hold)             r_hold <= Rx_DATA;
      else if (w_err || w_tmo)     r_hold <= 8'h00;
      if (w_load_hold)             r_timer <= '0;
      else if (w_timer_inc)        r_timer <= r_timer + TW'(1);
      if (w_commit) begin
        r_digits <= {r_hold, Rx_DATA};
        r_mode   <= DATA;
      end else if (w_err) begin
        r_mode   <= ERROR;
      end
    end
  end

  // Free-running digit scan
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
    end else if (r_refresh == RW'(REFRESH_CYCLES - 1)) begin
      r_refresh <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  // Anode/segment decode from registered scan index, mode and digits
  always_comb begin
    AN = ~(4'b0001 << r_idx);
    case (r_mode)
      BLANK:   SEG = 7'b1111111;
      ERROR:   SEG = 7'b0111111;
      DATA:    SEG = hex7(r_digits[r_idx]);
      default: SEG = 7'b1111111;
    endcase
  end

endmodule
